event_dispatcher: RTL and testbench

EVENT_DISPATCHER -- requirements
Module: event_dispatcher

---
 rtl/evt_pkg.sv | 46 ++++
 rtl/evt_min_queue.sv | 94 +++++++++
 rtl/event_dispatcher.sv | 228 ++++++++++++++++++++++
 tb/tb_event_dispatcher.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : evt_pkg                                                      |
// | Shared definitions for the event dispatcher: message field layout,     |
// | LP id width helper, FSM state encoding and the null-message constant.  |
// | Message layout: [TIME_WID-1:0] time, [TIME_WID +: LP_W] LP id,         |
// | bit TIME_WID+LP_W anti flag; any higher bits are payload.              |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package evt_pkg;

   // The time field always starts at bit 0 of a message.
   localparam int TIME_LSB = 0;

   // Width of the LP id field; at least one bit even for a single LP.
   function automatic int lp_w(input int num_lp);
      return (num_lp > 1) ? $clog2(num_lp) : 1;
   endfunction

   function automatic int id_lsb(input int time_wid);
      return time_wid;
   endfunction

   function automatic int anti_bit(input int time_wid, input int lpw);
      return time_wid + lpw;
   endfunction

   // Null message: anti=1, id=0, time=0. Only bits [anti:0] take part in
   // the comparison; payload bits above the anti flag are ignored.
   function automatic logic [63:0] null_msg(input int time_wid, input int lpw);
      logic [63:0] m;
      m = '0;
      m[time_wid + lpw] = 1'b1;
      return m;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INIT     = 3'd1,
      ST_READY    = 3'd2,
      ST_RUNNING  = 3'd3,
      ST_FINISHED = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/evt_min_queue.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : evt_min_queue                                                |
// | Sorted priority queue. Entries are kept in ascending key order, so     |
// | the head is always the minimum key; equal keys leave in arrival order. |
// | Ports : clk, rst_n (async, active-low), clr_i (sync clear),            |
// |         enq_i/enq_data_i (insert), deq_i (remove head),                |
// |         head_o (combinational, zero when empty), empty_o, full_o,      |
// |         count_o (occupancy).                                           |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module evt_min_queue
   import evt_pkg::*;
#(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32,
   parameter int KEY_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr_i,
   input  logic                     enq_i,
   input  logic [WIDTH-1:0]         enq_data_i,
   input  logic                     deq_i,
   output logic [WIDTH-1:0]         head_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] shf   [DEPTH];
   logic [DEPTH-1:0] le;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_post;
   logic             do_enq, do_deq;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign head_o  = empty_o ? '0 : mem_q[0];
   assign count_o = cnt_q;

   // A dequeue frees a slot, so a full queue may accept in the same cycle.
   assign do_deq = deq_i && !empty_o;
   assign do_enq = enq_i && (!full_o || do_deq);

   always_comb begin
      cnt_post = cnt_q - CW'(do_deq);
      for (int i = 0; i < DEPTH; i++) begin
         int j;
         j = (do_deq && (i < DEPTH - 1)) ? i + 1 : i;
         shf[i] = mem_q[j];
      end
      // le is a thermometer code: entries whose key is <= the new key stay
      // in front of it, which preserves FIFO order among equal keys.
      for (int i = 0; i < DEPTH; i++) begin
         le[i] = (CW'(i) < cnt_post) &&
                 (shf[i][KEY_W-1:0] <= enq_data_i[KEY_W-1:0]);
      end
      for (int i = 0; i < DEPTH; i++) begin
         int  k;
         logic prev_le;
         k       = (i == 0) ? 0 : i - 1;
         prev_le = (i == 0) ? 1'b1 : le[k];
         if (!do_enq || le[i])
            mem_d[i] = shf[i];
         else if (prev_le)
            mem_d[i] = enq_data_i;
         else
            mem_d[i] = shf[k];
      end
      if (clr_i)
         cnt_d = '0;
      else
         cnt_d = cnt_q + CW'(do_enq) - CW'(do_deq);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   // Storage needs no reset: occupancy alone defines which slots are live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         mem_q[i] <= mem_d[i];
   end

endmodule
`default_nettype wire

// File: rtl/event_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : event_dispatcher                                             |
// | PHOLD event dispatcher: seeds one event per LP, then receives events   |
// | from cores, keeps them time-ordered and dispatches the earliest to an  |
// | idle core, tracking global virtual time until the run ends.            |
// | Ports : clk, rst_n (async, active-low), start,                         |
// |         core_rdy, core_evt_vld, core_evt_data, core_evt_ack,           |
// |         core_active, core_min_time, disp_vld, disp_data, gvt,          |
// |         rtn_vld, q_count.                                              |
// | Option: DISPATCH_STATS_EN adds stat_disp, stat_rcv, stat_null.         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module event_dispatcher
   import evt_pkg::*;
#(
   parameter int NUM_CORE     = 4,
   parameter int NUM_LP       = 8,
   parameter int TIME_WID     = 16,
   parameter int MSG_WID      = 32,
   parameter int Q_DEPTH      = 32,
   parameter int SIM_END_TIME = 16000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [NUM_CORE-1:0]          core_rdy,
   input  logic [NUM_CORE-1:0]          core_evt_vld,
   input  logic [NUM_CORE*MSG_WID-1:0]  core_evt_data,
   output logic [NUM_CORE-1:0]          core_evt_ack,
   input  logic [NUM_CORE-1:0]          core_active,
   input  logic [NUM_CORE*TIME_WID-1:0] core_min_time,
   output logic [NUM_CORE-1:0]          disp_vld,
   output logic [MSG_WID-1:0]           disp_data,
   output logic [TIME_WID-1:0]          gvt,
   output logic                         rtn_vld,
   output logic [$clog2(Q_DEPTH):0]     q_count
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]                  stat_disp,
   output logic [31:0]                  stat_rcv,
   output logic [31:0]                  stat_null
`endif
);

   localparam int   LP_W     = lp_w(NUM_LP);
   localparam int   ID_LSB   = id_lsb(TIME_WID);
   localparam int   ANTI_BIT = anti_bit(TIME_WID, LP_W);
   localparam int   PTR_W    = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
   localparam logic [63:0]         NULL_MSG = null_msg(TIME_WID, LP_W);
   localparam logic [LP_W-1:0]     LAST_LP  = LP_W'(NUM_LP - 1);
   localparam logic [TIME_WID-1:0] END_T    = TIME_WID'(SIM_END_TIME);

   // Round-robin pick: first requester at or after ptr, wrapping.
   function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_CORE-1:0] req,
                                                input logic [PTR_W-1:0]    ptr);
      logic [PTR_W-1:0] idx;
      logic             found;
      int               j;
      idx   = ptr;
      found = 1'b0;
      for (int i = 0; i < NUM_CORE; i++) begin
         j = int'(ptr) + i;
         if (j >= NUM_CORE)
            j = j - NUM_CORE;
         if (!found && req[j]) begin
            idx   = PTR_W'(j);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] idx);
      return (int'(idx) == NUM_CORE - 1) ? '0 : idx + PTR_W'(1);
   endfunction

   state_e              state_q;
   logic [LP_W-1:0]     init_cnt_q;
   logic [TIME_WID-1:0] gvt_q;
   logic                rtn_vld_q;
   logic [PTR_W-1:0]    disp_ptr_q, rcv_ptr_q;

   logic                running, init_phase;
   logic [PTR_W-1:0]    disp_idx, rcv_idx;
   logic                q_clr, q_enq, q_deq, q_empty, q_full;
   logic [MSG_WID-1:0]  q_enq_data, q_head, rcv_msg, init_msg;
   logic                rcv_ok, rcv_null;
   logic                gvt_ok;
   logic [TIME_WID-1:0] gvt_min;

   assign running    = (state_q == ST_RUNNING);
   assign init_phase = (state_q == ST_INIT);

   assign disp_idx = rr_pick(core_rdy, disp_ptr_q);
   assign rcv_idx  = rr_pick(core_evt_vld, rcv_ptr_q);

   assign q_clr = (state_q == ST_IDLE) && start;
   assign q_deq = running && !q_empty && (|core_rdy);

   // Accept only when the queue has room now or the same-cycle dequeue
   // makes room.
   assign rcv_ok   = running && (|core_evt_vld) && (!q_full || q_deq);
   assign rcv_msg  = core_evt_data[int'(rcv_idx)*MSG_WID +: MSG_WID];
   assign rcv_null = (rcv_msg[ANTI_BIT:0] == NULL_MSG[ANTI_BIT:0]);

   always_comb begin
      init_msg = '0;
      init_msg[ID_LSB +: LP_W] = init_cnt_q;
   end

   assign q_enq      = init_phase || (rcv_ok && !rcv_null);
   assign q_enq_data = init_phase ? init_msg : rcv_msg;

   assign core_evt_ack = rcv_ok ? (NUM_CORE'(1) << rcv_idx) : '0;
   assign disp_vld     = q_deq  ? (NUM_CORE'(1) << disp_idx) : '0;
   assign disp_data    = q_head;
   assign gvt          = gvt_q;
   assign rtn_vld      = rtn_vld_q;

   evt_min_queue #(
      .DEPTH (Q_DEPTH),
      .WIDTH (MSG_WID),
      .KEY_W (TIME_WID)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (q_clr),
      .enq_i      (q_enq),
      .enq_data_i (q_enq_data),
      .deq_i      (q_deq),
      .head_o     (q_head),
      .empty_o    (q_empty),
      .full_o     (q_full),
      .count_o    (q_count)
   );

   // GVT candidate: queue head (if any) and every active core's minimum.
   always_comb begin
      gvt_ok  = !q_empty;
      gvt_min = q_head[TIME_LSB +: TIME_WID];
      for (int i = 0; i < NUM_CORE; i++) begin
         if (core_active[i]) begin
            if (!gvt_ok || (core_min_time[i*TIME_WID +: TIME_WID] < gvt_min))
               gvt_min = core_min_time[i*TIME_WID +: TIME_WID];
            gvt_ok = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         init_cnt_q <= '0;
         gvt_q      <= '0;
         rtn_vld_q  <= 1'b0;
         disp_ptr_q <= '0;
         rcv_ptr_q  <= '0;
      end else begin
         rtn_vld_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_INIT;
                  init_cnt_q <= '0;
                  gvt_q      <= '0;
               end
            end
            ST_INIT: begin
               if (init_cnt_q == LAST_LP)
                  state_q <= ST_READY;
               else
                  init_cnt_q <= init_cnt_q + LP_W'(1);
            end
            ST_READY: state_q <= ST_RUNNING;
            ST_RUNNING: begin
               if (gvt_ok)
                  gvt_q <= gvt_min;
               if (q_deq)
                  disp_ptr_q <= rr_next(disp_idx);
               if (rcv_ok)
                  rcv_ptr_q <= rr_next(rcv_idx);
               // rtn_vld is registered alongside the state so it is high
               // for exactly the FINISHED cycle.
               if (gvt_q > END_T) begin
                  state_q   <= ST_FINISHED;
                  rtn_vld_q <= 1'b1;
               end
            end
            ST_FINISHED: state_q <= ST_IDLE;
            default:     state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef DISPATCH_STATS_EN
   logic [31:0] stat_disp_q, stat_rcv_q, stat_null_q;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_disp_q <= '0;
         stat_rcv_q  <= '0;
         stat_null_q <= '0;
      end else if (q_clr) begin
         stat_disp_q <= '0;
         stat_rcv_q  <= '0;
         stat_null_q <= '0;
      end else begin
         if (q_deq)
            stat_disp_q <= sat_inc(stat_disp_q);
         if (rcv_ok && !rcv_null)
            stat_rcv_q <= sat_inc(stat_rcv_q);
         if (rcv_ok && rcv_null)
            stat_null_q <= sat_inc(stat_null_q);
      end
   end

   assign stat_disp = stat_disp_q;
   assign stat_rcv  = stat_rcv_q;
   assign stat_null = stat_null_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_event_dispatcher.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_event_dispatcher                                          |
// | Self-checking bench for event_dispatcher. Directed stimulus pushes the |
// | expected dispatches and acks into scoreboard queues; a monitor pops    |
// | and compares whenever the DUT presents disp_vld or core_evt_ack.       |
// | Option: DISPATCH_STATS_EN connects the statistics ports.               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_event_dispatcher;

   localparam int NC = 4;
   localparam int MW = 32;
   localparam int TW = 16;

   typedef struct {
      logic [NC-1:0] core;
      logic [MW-1:0] data;
   } disp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [NC-1:0]    core_rdy;
   logic [NC-1:0]    core_evt_vld;
   logic [NC*MW-1:0] core_evt_data;
   logic [NC-1:0]    core_evt_ack;
   logic [NC-1:0]    core_active;
   logic [NC*TW-1:0] core_min_time;
   logic [NC-1:0]    disp_vld;
   logic [MW-1:0]    disp_data;
   logic [TW-1:0]    gvt;
   logic             rtn_vld;
   logic [5:0]       q_count;
`ifdef DISPATCH_STATS_EN
   logic [31:0]      stat_disp, stat_rcv, stat_null;
`endif

   event_dispatcher #(
      .NUM_CORE(NC), .NUM_LP(8), .TIME_WID(TW), .MSG_WID(MW),
      .Q_DEPTH(32), .SIM_END_TIME(16000)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .core_rdy      (core_rdy),
      .core_evt_vld  (core_evt_vld),
      .core_evt_data (core_evt_data),
      .core_evt_ack  (core_evt_ack),
      .core_active   (core_active),
      .core_min_time (core_min_time),
      .disp_vld      (disp_vld),
      .disp_data     (disp_data),
      .gvt           (gvt),
      .rtn_vld       (rtn_vld),
      .q_count       (q_count)
`ifdef DISPATCH_STATS_EN
      ,
      .stat_disp     (stat_disp),
      .stat_rcv      (stat_rcv),
      .stat_null     (stat_null)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_pass  = 0;
   int            n_total = 0;
   disp_t         exp_disp[$];
   logic [NC-1:0] exp_ack[$];
   disp_t         mon_d;
   logic [NC-1:0] mon_a;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Message with anti=0: id in [18:16], time in [15:0].
   function automatic logic [MW-1:0] mk(input int id, input int t);
      logic [MW-1:0] m;
      m        = '0;
      m[15:0]  = t[15:0];
      m[18:16] = id[2:0];
      return m;
   endfunction

   task automatic push_disp(input logic [NC-1:0] core, input logic [MW-1:0] data);
      disp_t d;
      d.core = core;
      d.data = data;
      exp_disp.push_back(d);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (disp_vld != '0) begin
            if (exp_disp.size() == 0)
               check("disp_unexpected", 64'(disp_vld), 64'd0);
            else begin
               mon_d = exp_disp.pop_front();
               check("disp_core", 64'(disp_vld), 64'(mon_d.core));
               check("disp_data", 64'(disp_data), 64'(mon_d.data));
            end
         end
         if (core_evt_ack != '0) begin
            if (exp_ack.size() == 0)
               check("ack_unexpected", 64'(core_evt_ack), 64'd0);
            else begin
               mon_a = exp_ack.pop_front();
               check("ack_core", 64'(core_evt_ack), 64'(mon_a));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Start a run, check the seeded queue, then drain the 8 seed events.
   task automatic run_init_drain();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (8) step();
      core_rdy = 4'hF;
      for (int k = 0; k < 8; k++)
         push_disp(NC'(1) << (k % 4), mk(k, 0));
      @(negedge clk);
      check("init_q_count", 64'(q_count), 64'd8);
      check("ready_no_disp", 64'(disp_vld), 64'd0);
      repeat (10) step();
      core_rdy = '0;
      @(negedge clk);
      check("seed_drain_q_count", 64'(q_count), 64'd0);
   endtask

   int hi_cnt;

   initial begin
      rst_n         = 1'b0;
      start         = 1'b0;
      core_rdy      = '0;
      core_evt_vld  = '0;
      core_evt_data = '0;
      core_active   = '0;
      core_min_time = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_q_count", 64'(q_count), 64'd0);
      check("rst_gvt", 64'(gvt), 64'd0);
      check("rst_rtn_vld", 64'(rtn_vld), 64'd0);
      check("rst_ack", 64'(core_evt_ack), 64'd0);
      check("rst_disp_vld", 64'(disp_vld), 64'd0);
      step();
      rst_n = 1'b1;

      // Seeding and first dispatches
      run_init_drain();

      // Times 5,3,9 from cores 0,1,2 leave as 3,5,9 to cores 0,1,2
      step();
      core_evt_vld = 4'b0001; core_evt_data[0*MW +: MW] = mk(1, 5);
      exp_ack.push_back(4'b0001);
      step();
      core_evt_vld = 4'b0010; core_evt_data[1*MW +: MW] = mk(2, 3);
      exp_ack.push_back(4'b0010);
      step();
      core_evt_vld = 4'b0100; core_evt_data[2*MW +: MW] = mk(3, 9);
      exp_ack.push_back(4'b0100);
      step();
      core_evt_vld = '0;
      step();
      @(negedge clk);
      check("three_q_count", 64'(q_count), 64'd3);
      check("gvt_head_min", 64'(gvt), 64'd3);
      step();
      push_disp(4'b0001, mk(2, 3));
      push_disp(4'b0010, mk(1, 5));
      push_disp(4'b0100, mk(3, 9));
      core_rdy = 4'hF;
      repeat (3) step();
      core_rdy = '0;
      @(negedge clk);
      check("three_drain_q_count", 64'(q_count), 64'd0);

      // Null message from core 3: acked, not enqueued
      step();
      core_evt_vld = 4'b1000; core_evt_data[3*MW +: MW] = 32'h0008_0000;
      exp_ack.push_back(4'b1000);
      step();
      core_evt_vld = '0;
      @(negedge clk);
      check("null_q_count", 64'(q_count), 64'd0);

      // Fill to 32 from core 0 (times 100..131)
      step();
      for (int i = 0; i < 32; i++) begin
         core_evt_vld = 4'b0001;
         core_evt_data[0*MW +: MW] = mk(i % 8, 100 + i);
         exp_ack.push_back(4'b0001);
         step();
      end
      core_evt_vld = '0;
      @(negedge clk);
      check("full_q_count", 64'(q_count), 64'd32);
      step();
      core_evt_vld = 4'b0110;
      core_evt_data[1*MW +: MW] = mk(2, 50);
      core_evt_data[2*MW +: MW] = mk(3, 60);
      step();
      step();
      @(negedge clk);
      check("full_no_ack", 64'(core_evt_ack), 64'd0);
      check("full_hold_q_count", 64'(q_count), 64'd32);
      step();
      push_disp(4'b0001, mk(0, 100));
      exp_ack.push_back(4'b0010);
      core_rdy = 4'b0001;
      step();
      core_rdy     = '0;
      core_evt_vld = '0;
      @(negedge clk);
      check("full_swap_q_count", 64'(q_count), 64'd32);

      // Drain 20: time 50 first, then 101..119; cores rotate from 1
      step();
      for (int j = 0; j < 20; j++)
         push_disp(NC'(1) << ((1 + j) % 4), (j == 0) ? mk(2, 50) : mk(j % 8, 100 + j));
      core_rdy = 4'hF;
      repeat (20) step();
      core_rdy = '0;
      @(negedge clk);
      check("partial_q_count", 64'(q_count), 64'd12);

      // Reset mid-run
      step();
      rst_n        = 1'b0;
      core_rdy     = 4'hF;
      core_evt_vld = 4'b0001;
      #1;
      check("midrst_q_count", 64'(q_count), 64'd0);
      check("midrst_gvt", 64'(gvt), 64'd0);
      check("midrst_disp_vld", 64'(disp_vld), 64'd0);
      check("midrst_ack", 64'(core_evt_ack), 64'd0);
      check("midrst_disp_data", 64'(disp_data), 64'd0);
      check("midrst_rtn_vld", 64'(rtn_vld), 64'd0);
      step();
      step();
      core_rdy     = '0;
      core_evt_vld = '0;
      rst_n        = 1'b1;
      step();
      @(negedge clk);
      check("post_rst_q_count", 64'(q_count), 64'd0);

      // New run, then GVT and termination
      run_init_drain();
      step();
      core_active   = 4'b0100;
      core_min_time = 64'h0000_0064_0000_0000;
      core_evt_vld  = 4'b0001;
      core_evt_data[0*MW +: MW] = mk(1, 120);
      exp_ack.push_back(4'b0001);
      step();
      core_evt_vld = '0;
      step();
      @(negedge clk);
      check("gvt_core_min", 64'(gvt), 64'd100);
      step();
      core_active = '0;
      step();
      step();
      @(negedge clk);
      check("gvt_head_only", 64'(gvt), 64'd120);
      step();
      push_disp(4'b0001, mk(1, 120));
      core_rdy = 4'b0001;
      step();
      core_rdy = '0;
      step();
      @(negedge clk);
      check("gvt_hold_empty", 64'(gvt), 64'd120);
      check("gvt_hold_q_count", 64'(q_count), 64'd0);
      step();
      core_evt_vld = 4'b0001;
      core_evt_data[0*MW +: MW] = mk(5, 16001);
      exp_ack.push_back(4'b0001);
      step();
      core_evt_vld = '0;
      hi_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rtn_vld)
            hi_cnt++;
      end
      check("rtn_pulse_width", 64'(hi_cnt), 64'd1);
      check("gvt_final", 64'(gvt), 64'd16001);

      check("disp_sb_empty", 64'(exp_disp.size()), 64'd0);
      check("ack_sb_empty", 64'(exp_ack.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
